regfile_wb_scheduler: RTL and testbench

- Schedules the single write port of the 32x32 RegisterFile (x0 hardwired zero) between two writers: the single-cycle ALU writeback and a long-latency unit (load / mul-div completion).
- Holds a 32-entry pending-write scoreboard and stalls decode on RAW/WAW hazards against outstanding long-latency destinations.
- Sits between decode/writeback and RegisterFile; drives its should_write/write_addr/write_data directly.

---
 rtl/rv_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 66 ++++++
 rtl/regfile_wb_scheduler.sv | 121 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared register-file geometry and writeback-source encoding.
// Pure declarations; no logic, no latency, no backpressure.
package rv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LU   = 2'd2
    } wb_src_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for long-latency destinations with RAW/WAW hazard detect.
// Hazard is combinational from registered busy bits; set/clear land at the next edge.
// Stalls decode while any used operand or destination is still pending.
module regfile_scoreboard
    import rv_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dec_valid,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    input  logic                  dec_uses_rs1,
    input  logic                  dec_uses_rs2,
    input  logic                  dec_writes_rd,
    input  logic                  dec_is_long,
    input  logic                  clr_vld,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    output logic                  issue_stall,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic                  sb_error
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                sb_error_q, sb_error_d;
    logic                set_vld;

    // No bypass: a bit clearing this cycle still stalls until it is gone from busy_q.
    always_comb begin
        issue_stall = dec_valid & ((dec_uses_rs1  & busy_q[dec_rs1]) |
                                   (dec_uses_rs2  & busy_q[dec_rs2]) |
                                   (dec_writes_rd & busy_q[dec_rd]));
        set_vld     = dec_valid & dec_is_long & dec_writes_rd & ~issue_stall &
                      (dec_rd != '0);
    end

    // Clear is applied before set so a forced same-register collision leaves it busy.
    always_comb begin
        busy_d     = busy_q;
        sb_error_d = sb_error_q;
        if (clr_vld) begin
            if (!busy_q[clr_addr] && (clr_addr != '0)) begin
                sb_error_d = 1'b1;
            end
            busy_d[clr_addr] = 1'b0;
        end
        if (set_vld) begin
            busy_d[dec_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q     <= '0;
            sb_error_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            sb_error_q <= sb_error_d;
        end
    end

    assign busy_mask = busy_q;
    assign sb_error  = sb_error_q;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the single register-file write port between ALU and long-unit writebacks.
// Grant and write are combinational in the same cycle; scoreboard updates at the edge.
// ALU wins by default; after STARVE_LIMIT+1 denied long cycles the ALU is held for one cycle.
module regfile_wb_scheduler
    import rv_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dec_valid,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    input  logic                  dec_uses_rs1,
    input  logic                  dec_uses_rs2,
    input  logic                  dec_writes_rd,
    input  logic                  dec_is_long,
    output logic                  issue_stall,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_stall,
    input  logic                  lu_valid,
    input  logic [REG_ADDR_W-1:0] lu_addr,
    input  logic [XLEN-1:0]       lu_data,
    output logic                  lu_ready,
    output logic                  rf_should_write,
    output logic [REG_ADDR_W-1:0] rf_write_addr,
    output logic [XLEN-1:0]       rf_write_data,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic                  sb_error
);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             force_long_q, force_long_d;
    logic             alu_req;
    logic             lu_fire;
    logic             lu_denied;
    wb_src_e          wb_src;

    regfile_scoreboard u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .dec_valid     (dec_valid),
        .dec_rs1       (dec_rs1),
        .dec_rs2       (dec_rs2),
        .dec_rd        (dec_rd),
        .dec_uses_rs1  (dec_uses_rs1),
        .dec_uses_rs2  (dec_uses_rs2),
        .dec_writes_rd (dec_writes_rd),
        .dec_is_long   (dec_is_long),
        .clr_vld       (lu_fire),
        .clr_addr      (lu_addr),
        .issue_stall   (issue_stall),
        .busy_mask     (busy_mask),
        .sb_error      (sb_error)
    );

    // An ALU write to x0 is discarded, so it never competes for the port.
    always_comb begin
        alu_req  = alu_valid & (alu_addr != '0);
        lu_ready = 1'b1;
        wb_src   = WB_NONE;
        if (force_long_q) begin
            if (lu_valid && (lu_addr != '0)) wb_src = WB_LU;
        end else if (alu_req) begin
            lu_ready = 1'b0;
            wb_src   = WB_ALU;
        end else if (lu_valid && (lu_addr != '0)) begin
            wb_src = WB_LU;
        end
    end

    always_comb begin
        rf_should_write = 1'b0;
        rf_write_addr   = lu_addr;
        rf_write_data   = lu_data;
        unique case (wb_src)
            WB_ALU: begin
                rf_should_write = 1'b1;
                rf_write_addr   = alu_addr;
                rf_write_data   = alu_data;
            end
            WB_LU:   rf_should_write = 1'b1;
            default: rf_should_write = 1'b0;
        endcase
    end

    assign lu_fire   = lu_valid & lu_ready;
    assign lu_denied = lu_valid & ~lu_ready;

    // force_long only ever rises on a denied cycle, and a forced cycle always grants the long unit.
    always_comb begin
        starve_cnt_d = '0;
        force_long_d = force_long_q;
        if (lu_denied) begin
            starve_cnt_d = (starve_cnt_q == CNT_W'(STARVE_LIMIT)) ? starve_cnt_q
                                                                   : starve_cnt_q + CNT_W'(1);
        end
        if (lu_denied && (starve_cnt_q == CNT_W'(STARVE_LIMIT))) begin
            force_long_d = 1'b1;
        end else if (lu_fire || !lu_valid) begin
            force_long_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
            force_long_q <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            force_long_q <= force_long_d;
        end
    end

    assign alu_stall = force_long_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, then
// randomized traffic scored against a behavioural model of the scheduling rules.
module tb_regfile_wb_scheduler;
    import rv_pkg::*;

    localparam int LIMIT = 4;

    logic        clk, reset;
    logic        dec_valid, dec_uses_rs1, dec_uses_rs2, dec_writes_rd, dec_is_long;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        issue_stall, alu_valid, alu_stall, lu_valid, lu_ready;
    logic [4:0]  alu_addr, lu_addr, rf_write_addr;
    logic [31:0] alu_data, lu_data, rf_write_data, busy_mask;
    logic        rf_should_write, sb_error;

    regfile_wb_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
        .dec_writes_rd(dec_writes_rd), .dec_is_long(dec_is_long),
        .issue_stall(issue_stall),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_stall(alu_stall),
        .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
        .rf_should_write(rf_should_write), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .busy_mask(busy_mask), .sb_error(sb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned dv, rs1, rs2, rd, u1, u2, wr, lng;
        int unsigned av, aa, ad;
        int unsigned lv, la, ld;
        int unsigned e_stall, e_lurdy, e_astall, e_we, e_wa, e_wd, e_busy, e_err;
    } vec_t;

    vec_t vecs[11];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    bit          m_busy[32];
    bit          m_err;
    int          m_run;
    int          blist[$];
    logic        e_force, e_alu_req, e_lurdy, e_stall, e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_mask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic clear_inputs();
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
        dec_uses_rs1 = 0; dec_uses_rs2 = 0; dec_writes_rd = 0; dec_is_long = 0;
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        lu_valid = 0; lu_addr = 0; lu_data = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        clear_inputs();
        dec_valid = 1; dec_writes_rd = 1; dec_is_long = 1; dec_rd = rd;
        next_cycle();
        clear_inputs();
    endtask

    task automatic drive_vec(input vec_t v);
        dec_valid = v.dv[0]; dec_rs1 = v.rs1[4:0]; dec_rs2 = v.rs2[4:0]; dec_rd = v.rd[4:0];
        dec_uses_rs1 = v.u1[0]; dec_uses_rs2 = v.u2[0];
        dec_writes_rd = v.wr[0]; dec_is_long = v.lng[0];
        alu_valid = v.av[0]; alu_addr = v.aa[4:0]; alu_data = v.ad;
        lu_valid = v.lv[0]; lu_addr = v.la[4:0]; lu_data = v.ld;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("vec%0d issue_stall", i), 32'(issue_stall), v.e_stall);
        chk($sformatf("vec%0d lu_ready", i), 32'(lu_ready), v.e_lurdy);
        chk($sformatf("vec%0d alu_stall", i), 32'(alu_stall), v.e_astall);
        chk($sformatf("vec%0d rf_should_write", i), 32'(rf_should_write), v.e_we);
        if (v.e_we != 0) begin
            chk($sformatf("vec%0d rf_write_addr", i), 32'(rf_write_addr), v.e_wa);
            chk($sformatf("vec%0d rf_write_data", i), rf_write_data, v.e_wd);
        end
        chk($sformatf("vec%0d busy_mask", i), busy_mask, v.e_busy);
        chk($sformatf("vec%0d sb_error", i), 32'(sb_error), v.e_err);
    endtask

    initial begin
        // dv rs1 rs2 rd u1 u2 wr lng | av aa ad | lv la ld | stall lurdy astall we wa wd busy err
        vecs[0]  = '{1,0,0,5,0,0,1,1, 0,0,0,       0,0,0,         0,1,0,0,0,0,32'h0,0};
        vecs[1]  = '{1,5,0,0,1,0,0,0, 0,0,0,       0,0,0,         1,1,0,0,0,0,32'h20,0};
        vecs[2]  = '{1,5,0,0,1,0,0,0, 0,0,0,       1,5,32'hDEAD,  1,1,0,1,5,32'hDEAD,32'h20,0};
        vecs[3]  = '{1,5,0,6,1,0,1,1, 0,0,0,       0,0,0,         0,1,0,0,0,0,32'h0,0};
        vecs[4]  = '{0,0,0,0,0,0,0,0, 1,3,32'h33,  1,6,32'h66,    0,0,0,1,3,32'h33,32'h40,0};
        vecs[5]  = '{0,0,0,0,0,0,0,0, 0,0,0,       1,6,32'h66,    0,1,0,1,6,32'h66,32'h40,0};
        vecs[6]  = '{1,0,0,0,0,0,1,1, 0,0,0,       0,0,0,         0,1,0,0,0,0,32'h0,0};
        vecs[7]  = '{1,0,0,9,0,0,1,1, 0,0,0,       0,0,0,         0,1,0,0,0,0,32'h0,0};
        vecs[8]  = '{1,0,0,9,0,0,1,0, 1,0,32'hBAD, 1,9,32'h99,    1,1,0,1,9,32'h99,32'h200,0};
        vecs[9]  = '{0,0,0,0,0,0,0,0, 0,0,0,       0,0,0,         0,1,0,0,0,0,32'h0,0};
        vecs[10] = '{1,0,0,9,0,0,1,0, 0,0,0,       0,0,0,         0,1,0,0,0,0,32'h0,0};

        clear_inputs();
        reset = 1'b1;
        #1;
        chk("reset issue_stall", 32'(issue_stall), 32'd0);
        chk("reset alu_stall", 32'(alu_stall), 32'd0);
        chk("reset busy_mask", busy_mask, 32'd0);
        chk("reset sb_error", 32'(sb_error), 32'd0);
        chk("reset lu_ready", 32'(lu_ready), 32'd1);
        next_cycle();
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive_vec(vecs[i]);
            #4;
            check_vec(i, vecs[i]);
            next_cycle();
        end

        // Starvation: ALU busy every cycle, long unit waits STARVE_LIMIT+1 cycles.
        do_reset();
        issue_long(5'd4);
        for (int i = 1; i <= LIMIT + 2; i++) begin
            alu_valid = 1; alu_addr = 5'd1; alu_data = 32'h100 + 32'(i);
            lu_valid = 1; lu_addr = 5'd4; lu_data = 32'hAAAA;
            #4;
            if (i <= LIMIT + 1) begin
                chk($sformatf("starve c%0d alu_stall", i), 32'(alu_stall), 32'd0);
                chk($sformatf("starve c%0d lu_ready", i), 32'(lu_ready), 32'd0);
                chk($sformatf("starve c%0d wr_addr", i), 32'(rf_write_addr), 32'd1);
                chk($sformatf("starve c%0d wr_data", i), rf_write_data, 32'h100 + 32'(i));
            end else begin
                chk("starve forced alu_stall", 32'(alu_stall), 32'd1);
                chk("starve forced lu_ready", 32'(lu_ready), 32'd1);
                chk("starve forced we", 32'(rf_should_write), 32'd1);
                chk("starve forced wr_addr", 32'(rf_write_addr), 32'd4);
                chk("starve forced wr_data", rf_write_data, 32'hAAAA);
            end
            next_cycle();
        end
        lu_valid = 0;
        #4;
        chk("starve after alu_stall", 32'(alu_stall), 32'd0);
        chk("starve held alu we", 32'(rf_should_write), 32'd1);
        chk("starve held alu addr", 32'(rf_write_addr), 32'd1);
        chk("starve held alu data", rf_write_data, 32'h106);
        chk("starve busy cleared", busy_mask, 32'd0);
        next_cycle();

        // Completion to a register that was never issued.
        do_reset();
        lu_valid = 1; lu_addr = 5'd7; lu_data = 32'h77;
        #4;
        chk("sberr write we", 32'(rf_should_write), 32'd1);
        chk("sberr write addr", 32'(rf_write_addr), 32'd7);
        chk("sberr before edge", 32'(sb_error), 32'd0);
        next_cycle();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            #4;
            chk($sformatf("sberr sticky c%0d", i), 32'(sb_error), 32'd1);
            next_cycle();
        end

        // Async reset with busy bits, force_long and sb_error all set.
        issue_long(5'd4);
        issue_long(5'd5);
        for (int i = 0; i <= LIMIT; i++) begin
            alu_valid = 1; alu_addr = 5'd1; alu_data = 32'h5A;
            lu_valid = 1; lu_addr = 5'd4; lu_data = 32'h44;
            next_cycle();
        end
        #4;
        chk("pre-arst alu_stall", 32'(alu_stall), 32'd1);
        chk("pre-arst busy_mask", busy_mask, 32'h30);
        chk("pre-arst sb_error", 32'(sb_error), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("arst busy_mask", busy_mask, 32'd0);
        chk("arst alu_stall", 32'(alu_stall), 32'd0);
        chk("arst sb_error", 32'(sb_error), 32'd0);
        chk("arst lu_ready", 32'(lu_ready), 32'd0);
        chk("arst alu we", 32'(rf_should_write), 32'd1);
        chk("arst alu addr", 32'(rf_write_addr), 32'd1);
        next_cycle();
        reset = 1'b0;

        // Randomized traffic against the reference model.
        do_reset();
        for (int r = 0; r < 32; r++) m_busy[r] = 0;
        m_err = 0;
        m_run = 0;
        for (int n = 0; n < 400; n++) begin
            dec_valid     = 1'($urandom_range(0, 1));
            dec_rs1       = 5'($urandom_range(0, 7));
            dec_rs2       = 5'($urandom_range(0, 7));
            dec_rd        = 5'($urandom_range(0, 7));
            dec_uses_rs1  = 1'($urandom_range(0, 1));
            dec_uses_rs2  = 1'($urandom_range(0, 1));
            dec_writes_rd = 1'($urandom_range(0, 1));
            dec_is_long   = 1'($urandom_range(0, 1));
            alu_valid     = ($urandom_range(0, 9) < 7);
            alu_addr      = 5'($urandom_range(0, 7));
            alu_data      = $urandom;
            lu_valid      = ($urandom_range(0, 9) < 6);
            lu_data       = $urandom;
            blist.delete();
            for (int r = 1; r < 32; r++) if (m_busy[r]) blist.push_back(r);
            if (blist.size() > 0 && $urandom_range(0, 7) != 0)
                lu_addr = 5'(blist[$urandom_range(0, blist.size() - 1)]);
            else
                lu_addr = 5'($urandom_range(0, 7));

            e_force   = (m_run >= LIMIT + 1);
            e_alu_req = alu_valid && (alu_addr != 0);
            e_lurdy   = e_force || !e_alu_req;
            e_stall   = dec_valid && ((dec_uses_rs1 && m_busy[dec_rs1]) ||
                                      (dec_uses_rs2 && m_busy[dec_rs2]) ||
                                      (dec_writes_rd && m_busy[dec_rd]));
            e_we      = (e_alu_req && !e_force) || (lu_valid && e_lurdy && lu_addr != 0);
            e_wa      = (e_alu_req && !e_force) ? alu_addr : lu_addr;
            e_wd      = (e_alu_req && !e_force) ? alu_data : lu_data;
            e_mask    = 0;
            for (int r = 0; r < 32; r++) if (m_busy[r]) e_mask[r] = 1'b1;

            #4;
            chk($sformatf("rnd%0d issue_stall", n), 32'(issue_stall), 32'(e_stall));
            chk($sformatf("rnd%0d lu_ready", n), 32'(lu_ready), 32'(e_lurdy));
            chk($sformatf("rnd%0d alu_stall", n), 32'(alu_stall), 32'(e_force));
            chk($sformatf("rnd%0d we", n), 32'(rf_should_write), 32'(e_we));
            if (e_we) begin
                chk($sformatf("rnd%0d wr_addr", n), 32'(rf_write_addr), 32'(e_wa));
                chk($sformatf("rnd%0d wr_data", n), rf_write_data, e_wd);
            end
            chk($sformatf("rnd%0d busy_mask", n), busy_mask, e_mask);
            chk($sformatf("rnd%0d sb_error", n), 32'(sb_error), 32'(m_err));

            if (lu_valid && e_lurdy) begin
                if (lu_addr != 0 && !m_busy[lu_addr]) m_err = 1;
                m_busy[lu_addr] = 0;
            end
            if (dec_valid && dec_is_long && dec_writes_rd && !e_stall && dec_rd != 0)
                m_busy[dec_rd] = 1;
            m_run = (lu_valid && !e_lurdy) ? m_run + 1 : 0;
            next_cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
